// File: rtl/stream_packet_arbiter.sv
// stream_packet_arbiter
//   Two-requester Avalon-ST packet arbiter. Ownership is granted for a whole
//   packet and handed back only after the owner's end-of-packet beat is
//   accepted. Each packet is followed by one idle bubble cycle. A round-robin
//   pointer picks the port not granted last when both ports request at once.
//   The datapath is purely combinational (readyLatency 0).
//
// Optional feature (macro STREAM_ARB_STATS_EN):
//   Adds in0_pkt_count / in1_pkt_count. Each is a 32-bit count of accepted
//   start-of-packet beats from that port; it wraps and is cleared by reset.
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   inN_data/empty       : requester beat payload and empty-byte count
//   inN_valid/sop/eop    : requester qualifiers
//   inN_ready            : per-requester backpressure
//   out_*                : shared output stream, out_ready is downstream ready
//   grant                : one-hot owner, 2'b00 when idle
//   inN_pkt_count        : packet counters (STREAM_ARB_STATS_EN only)

module stream_packet_arbiter #(
  parameter int unsigned DATA_BYTES = 8,
  localparam int unsigned EmptyW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_BYTES*8-1:0] in0_data,
  input  logic [EmptyW-1:0]       in0_empty,
  input  logic                    in0_valid,
  input  logic                    in0_startofpacket,
  input  logic                    in0_endofpacket,
  output logic                    in0_ready,
  input  logic [DATA_BYTES*8-1:0] in1_data,
  input  logic [EmptyW-1:0]       in1_empty,
  input  logic                    in1_valid,
  input  logic                    in1_startofpacket,
  input  logic                    in1_endofpacket,
  output logic                    in1_ready,
  output logic [DATA_BYTES*8-1:0] out_data,
  output logic [EmptyW-1:0]       out_empty,
  output logic                    out_valid,
  output logic                    out_startofpacket,
  output logic                    out_endofpacket,
  input  logic                    out_ready,
  output logic [1:0]              grant
`ifdef STREAM_ARB_STATS_EN
  ,
  output logic [31:0]             in0_pkt_count,
  output logic [31:0]             in1_pkt_count
`endif
);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e state_q, state_d;
  // Port favoured on a tie: 0 -> port 0, 1 -> port 1.
  logic   prio_q, prio_d;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      StIdle: begin
        if (in0_valid && (!in1_valid || !prio_q)) begin
          state_d = StGrant0;
          prio_d  = 1'b1;
        end else if (in1_valid) begin
          state_d = StGrant1;
          prio_d  = 1'b0;
        end
      end
      StGrant0: begin
        if (in0_valid && out_ready && in0_endofpacket) state_d = StIdle;
      end
      StGrant1: begin
        if (in1_valid && out_ready && in1_endofpacket) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: the owner's stream is muxed straight through.
  always_comb begin
    out_data          = '0;
    out_empty         = '0;
    out_valid         = 1'b0;
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    in0_ready         = 1'b0;
    in1_ready         = 1'b0;
    grant             = 2'b00;
    case (state_q)
      StGrant0: begin
        out_data          = in0_data;
        out_empty         = in0_empty;
        out_valid         = in0_valid;
        out_startofpacket = in0_startofpacket;
        out_endofpacket   = in0_endofpacket;
        in0_ready         = out_ready;
        grant             = 2'b01;
      end
      StGrant1: begin
        out_data          = in1_data;
        out_empty         = in1_empty;
        out_valid         = in1_valid;
        out_startofpacket = in1_startofpacket;
        out_endofpacket   = in1_endofpacket;
        in1_ready         = out_ready;
        grant             = 2'b10;
      end
      default: ;
    endcase
  end

`ifdef STREAM_ARB_STATS_EN
  logic [31:0] in0_pkt_count_q, in0_pkt_count_d;
  logic [31:0] in1_pkt_count_q, in1_pkt_count_d;

  always_comb begin
    in0_pkt_count_d = in0_pkt_count_q;
    in1_pkt_count_d = in1_pkt_count_q;
    if (in0_valid && in0_ready && in0_startofpacket) in0_pkt_count_d = in0_pkt_count_q + 32'd1;
    if (in1_valid && in1_ready && in1_startofpacket) in1_pkt_count_d = in1_pkt_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in0_pkt_count_q <= '0;
      in1_pkt_count_q <= '0;
    end else begin
      in0_pkt_count_q <= in0_pkt_count_d;
      in1_pkt_count_q <= in1_pkt_count_d;
    end
  end

  assign in0_pkt_count = in0_pkt_count_q;
  assign in1_pkt_count = in1_pkt_count_q;
`endif

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Directed testbench for stream_packet_arbiter (DATA_BYTES = 8).
module tb_stream_packet_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in0_data = '0, in1_data = '0;
  logic [2:0]  in0_empty = '0, in1_empty = '0;
  logic        in0_valid = 1'b0, in0_startofpacket = 1'b0, in0_endofpacket = 1'b0;
  logic        in1_valid = 1'b0, in1_startofpacket = 1'b0, in1_endofpacket = 1'b0;
  logic        in0_ready, in1_ready;
  logic [63:0] out_data;
  logic [2:0]  out_empty;
  logic        out_valid, out_startofpacket, out_endofpacket;
  logic        out_ready = 1'b1;
  logic [1:0]  grant;
`ifdef STREAM_ARB_STATS_EN
  logic [31:0] in0_pkt_count, in1_pkt_count;
`endif

  int checks = 0;
  int failures = 0;

  stream_packet_arbiter #(.DATA_BYTES(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .in0_data          (in0_data),
    .in0_empty         (in0_empty),
    .in0_valid         (in0_valid),
    .in0_startofpacket (in0_startofpacket),
    .in0_endofpacket   (in0_endofpacket),
    .in0_ready         (in0_ready),
    .in1_data          (in1_data),
    .in1_empty         (in1_empty),
    .in1_valid         (in1_valid),
    .in1_startofpacket (in1_startofpacket),
    .in1_endofpacket   (in1_endofpacket),
    .in1_ready         (in1_ready),
    .out_data          (out_data),
    .out_empty         (out_empty),
    .out_valid         (out_valid),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_ready         (out_ready),
    .grant             (grant)
`ifdef STREAM_ARB_STATS_EN
    ,
    .in0_pkt_count     (in0_pkt_count),
    .in1_pkt_count     (in1_pkt_count)
`endif
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic s, input logic e, input logic [63:0] d,
                        input logic [2:0] em);
    in0_valid = v; in0_startofpacket = s; in0_endofpacket = e; in0_data = d; in0_empty = em;
  endtask

  task automatic drive1(input logic v, input logic s, input logic e, input logic [63:0] d,
                        input logic [2:0] em);
    in1_valid = v; in1_startofpacket = s; in1_endofpacket = e; in1_data = d; in1_empty = em;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive0(1'b1, 1'b1, 1'b0, 64'h11, 3'd0);
    drive1(1'b1, 1'b1, 1'b0, 64'h22, 3'd0);
    step(); step(); #1;
    checks++;
    if (grant !== 2'b00) begin
      failures++; $display("FAIL reset_grant got=%b want=00", grant);
    end
    checks++;
    if ({out_valid, in0_ready, in1_ready} !== 3'b000) begin
      failures++; $display("FAIL reset_ready got=%b want=000", {out_valid, in0_ready, in1_ready});
    end
`ifdef STREAM_ARB_STATS_EN
    checks++;
    if (in0_pkt_count !== 32'd0 || in1_pkt_count !== 32'd0) begin
      failures++; $display("FAIL reset_counts got=%h/%h want=0/0", in0_pkt_count, in1_pkt_count);
    end
`endif
  endtask

  // Both ports requesting in the first cycle after reset.
  task automatic test_round_robin();
    reset = 1'b1;
    drive0(1'b1, 1'b1, 1'b0, 64'hA0, 3'd0);
    drive1(1'b1, 1'b1, 1'b1, 64'hB0, 3'd2);
    step();
    reset = 1'b0; #1;
    checks++;
    if (grant !== 2'b00 || in0_ready !== 1'b0) begin
      failures++; $display("FAIL rr_first_idle got=%b/%b want=00/0", grant, in0_ready);
    end
    step(); #1;
    checks++;
    if (grant !== 2'b01 || out_data !== 64'hA0 || in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
      failures++;
      $display("FAIL rr_grant0 got=%b %h %b%b want=01 a0 10", grant, out_data, in0_ready, in1_ready);
    end
    step();
    drive0(1'b1, 1'b0, 1'b1, 64'hA1, 3'd5); #1;
    checks++;
    if (out_data !== 64'hA1 || out_endofpacket !== 1'b1 || out_empty !== 3'd5) begin
      failures++;
      $display("FAIL rr_eop got=%h %b %0d want=a1 1 5", out_data, out_endofpacket, out_empty);
    end
    step();
    drive0(1'b1, 1'b1, 1'b1, 64'hC0, 3'd0); #1;
    checks++;
    if (grant !== 2'b00 || out_valid !== 1'b0) begin
      failures++; $display("FAIL rr_bubble got=%b/%b want=00/0", grant, out_valid);
    end
    step(); #1;
    checks++;
    if (grant !== 2'b10 || out_data !== 64'hB0 || in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
      failures++;
      $display("FAIL rr_grant1 got=%b %h %b%b want=10 b0 10", grant, out_data, in1_ready, in0_ready);
    end
    step();
    drive1(1'b0, 1'b0, 1'b0, 64'h0, 3'd0); #1;
    checks++;
    if (grant !== 2'b00) begin
      failures++; $display("FAIL rr_bubble2 got=%b want=00", grant);
    end
    step(); #1;
    checks++;
    if (grant !== 2'b01 || out_data !== 64'hC0) begin
      failures++; $display("FAIL rr_back_to0 got=%b %h want=01 c0", grant, out_data);
    end
    step();
    drive0(1'b0, 1'b0, 1'b0, 64'h0, 3'd0); #1;
    checks++;
    if (grant !== 2'b00) begin
      failures++; $display("FAIL rr_end_idle got=%b want=00", grant);
    end
  endtask

  task automatic test_single_port();
    int k;
    logic [63:0] exp_d [3];
    exp_d[0] = 64'h100; exp_d[1] = 64'h101; exp_d[2] = 64'h102;
    drive0(1'b1, 1'b1, 1'b0, exp_d[0], 3'd0); #1;
    checks++;
    if (grant !== 2'b00 || in0_ready !== 1'b0) begin
      failures++; $display("FAIL single_c1 got=%b/%b want=00/0", grant, in0_ready);
    end
    for (k = 0; k < 3; k++) begin
      step();
      drive0(1'b1, k == 0, k == 2, exp_d[k], (k == 2) ? 3'd3 : 3'd0); #1;
      checks++;
      if (grant !== 2'b01 || out_valid !== 1'b1 || out_data !== exp_d[k] ||
          out_startofpacket !== (k == 0) || out_endofpacket !== (k == 2)) begin
        failures++;
        $display("FAIL single_beat%0d got=%b %b %h want=01 1 %h", k, grant, out_valid, out_data,
                 exp_d[k]);
      end
    end
    step();
    drive0(1'b0, 1'b0, 1'b0, 64'h0, 3'd0); #1;
    checks++;
    if (grant !== 2'b00 || out_valid !== 1'b0) begin
      failures++; $display("FAIL single_c5 got=%b/%b want=00/0", grant, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    drive1(1'b1, 1'b1, 1'b0, 64'hD0, 3'd0);
    drive0(1'b1, 1'b1, 1'b1, 64'hE0, 3'd0);
    out_ready = 1'b1; #1;
    step(); #1;
    checks++;
    if (grant !== 2'b10 || out_data !== 64'hD0 || in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_d0 got=%b %h %b%b want=10 d0 10", grant, out_data, in1_ready, in0_ready);
    end
    if (out_valid && out_ready) acc++;
    step();
    drive1(1'b1, 1'b0, 1'b0, 64'hD1, 3'd0);
    out_ready = 1'b0; #1;
    checks++;
    if (grant !== 2'b10 || in1_ready !== 1'b0 || in0_ready !== 1'b0 || out_data !== 64'hD1) begin
      failures++;
      $display("FAIL bp_stall got=%b %b%b %h want=10 00 d1", grant, in1_ready, in0_ready, out_data);
    end
    if (out_valid && out_ready) acc++;
    step();
    out_ready = 1'b1; #1;
    checks++;
    if (in1_ready !== 1'b1 || in0_ready !== 1'b0 || out_data !== 64'hD1) begin
      failures++; $display("FAIL bp_resume got=%b%b %h want=10 d1", in1_ready, in0_ready, out_data);
    end
    if (out_valid && out_ready) acc++;
    step();
    drive1(1'b1, 1'b0, 1'b1, 64'hD2, 3'd1); #1;
    checks++;
    if (out_data !== 64'hD2 || out_endofpacket !== 1'b1 || grant !== 2'b10) begin
      failures++; $display("FAIL bp_eop got=%h %b %b want=d2 1 10", out_data, out_endofpacket, grant);
    end
    if (out_valid && out_ready) acc++;
    checks++;
    if (acc !== 3) begin
      failures++; $display("FAIL bp_beats got=%0d want=3", acc);
    end
    step();
    drive1(1'b0, 1'b0, 1'b0, 64'h0, 3'd0); #1;
    checks++;
    if (grant !== 2'b00) begin
      failures++; $display("FAIL bp_bubble got=%b want=00", grant);
    end
    step(); #1;
    checks++;
    if (grant !== 2'b01 || out_data !== 64'hE0) begin
      failures++; $display("FAIL bp_then0 got=%b %h want=01 e0", grant, out_data);
    end
    step();
    drive0(1'b0, 1'b0, 1'b0, 64'h0, 3'd0); #1;
  endtask

  task automatic test_back_to_back();
    int beats = 0;
    drive0(1'b1, 1'b1, 1'b1, 64'hF0, 3'd0);
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (grant !== ((k % 2 == 1) ? 2'b01 : 2'b00) || out_valid !== (k % 2 == 1)) begin
        failures++; $display("FAIL b2b_cycle%0d got=%b/%b", k, grant, out_valid);
      end
      if (out_valid && out_ready) beats++;
      step();
    end
    drive0(1'b0, 1'b0, 1'b0, 64'h0, 3'd0);
    checks++;
    if (beats !== 3) begin
      failures++; $display("FAIL b2b_beats got=%0d want=3", beats);
    end
  endtask

  task automatic test_reset_mid_packet();
    drive0(1'b1, 1'b1, 1'b0, 64'h200, 3'd0);
    step(); #1;
    checks++;
    if (grant !== 2'b01 || out_data !== 64'h200) begin
      failures++; $display("FAIL rst_mid_b1 got=%b %h want=01 200", grant, out_data);
    end
    step();
    drive0(1'b1, 1'b0, 1'b0, 64'h201, 3'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive0(1'b1, 1'b0, 1'b0, 64'h202, 3'd0);
    drive1(1'b1, 1'b1, 1'b1, 64'h300, 3'd0); #1;
    checks++;
    if (grant !== 2'b00 || out_valid !== 1'b0 || in0_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_abort got=%b %b %b want=00 0 0", grant, out_valid, in0_ready);
    end
    step(); #1;
    checks++;
    if (grant !== 2'b01) begin
      failures++; $display("FAIL rst_mid_ptr got=%b want=01", grant);
    end
    drive0(1'b0, 1'b0, 1'b0, 64'h0, 3'd0);
    drive1(1'b0, 1'b0, 1'b0, 64'h0, 3'd0);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

`ifdef STREAM_ARB_STATS_EN
  task automatic test_stats_wrap();
    force dut.in1_pkt_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.in1_pkt_count_q;
    drive0(1'b1, 1'b1, 1'b1, 64'h400, 3'd0);
    step(); step();
    drive0(1'b0, 1'b0, 1'b0, 64'h0, 3'd0);
    drive1(1'b1, 1'b1, 1'b1, 64'h500, 3'd0);
    step(); step();
    drive1(1'b0, 1'b0, 1'b0, 64'h0, 3'd0); #1;
    checks++;
    if (in1_pkt_count !== 32'h0000_0000) begin
      failures++; $display("FAIL stats_wrap got=%h want=00000000", in1_pkt_count);
    end
    checks++;
    if (in0_pkt_count !== 32'd1) begin
      failures++; $display("FAIL stats_in0 got=%h want=00000001", in0_pkt_count);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single_port();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
`ifdef STREAM_ARB_STATS_EN
    test_stats_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
